// File: rtl/weddinglight_gen.sv
// Run-time selectable LED pattern generator: centre-out fill, edge-in fill,
// bouncing pair and single-bit chase, stepped by a programmable prescaler.
module weddinglight_gen #(
  parameter int WIDTH = 16,
  parameter int DIV_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [DIV_W-1:0] div,
  output logic [WIDTH-1:0] q,
  output logic             wrap
);

  localparam int H  = WIDTH / 2;
  localparam int IW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    M_OUT    = 2'd0,
    M_IN     = 2'd1,
    M_BOUNCE = 2'd2,
    M_CHASE  = 2'd3
  } mode_t;

  mode_t            mode_q;
  logic [IW-1:0]    idx;
  logic [DIV_W-1:0] cnt;
  logic [WIDTH-1:0] pat;
  logic             tick;
  logic             last;
  logic             mode_chg;
  int               last_idx;
  int               ix;
  int               p;

  assign tick     = (cnt >= div);
  assign mode_chg = (mode != mode_q);
  assign last     = (int'(idx) == last_idx);

  always_comb begin
    last_idx = WIDTH - 1;
    case (mode_q)
      M_OUT:    last_idx = H;
      M_IN:     last_idx = H;
      M_BOUNCE: last_idx = 2 * H - 3;
      M_CHASE:  last_idx = WIDTH - 1;
      default:  last_idx = WIDTH - 1;
    endcase
  end

  // Patterns are built bit by bit in int arithmetic so no intermediate value
  // can truncate, whatever the width.
  always_comb begin
    pat = '0;
    ix  = int'(idx);
    p   = (ix < H) ? ix : (2 * H - 2 - ix);
    for (int i = 0; i < WIDTH; i++) begin
      case (mode_q)
        M_OUT:    pat[i] = (i >= H - ix) && (i <= H - 1 + ix);
        M_IN:     pat[i] = (i < ix) || (i >= WIDTH - ix);
        M_BOUNCE: pat[i] = (i == H - 1 - p) || (i == H + p);
        M_CHASE:  pat[i] = (i == ix);
        default:  pat[i] = 1'b0;
      endcase
    end
  end

  // A mode change always restarts the new pattern from scratch, even while paused.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q <= M_OUT;
      idx    <= '0;
      cnt    <= '0;
      q      <= '0;
      wrap   <= 1'b0;
    end else if (mode_chg) begin
      mode_q <= mode_t'(mode);
      idx    <= '0;
      cnt    <= '0;
      q      <= '0;
      wrap   <= 1'b0;
    end else if (en) begin
      if (tick) begin
        cnt  <= '0;
        q    <= pat;
        idx  <= last ? '0 : idx + 1'b1;
        wrap <= last;
      end else begin
        cnt  <= cnt + 1'b1;
        wrap <= 1'b0;
      end
    end else begin
      wrap <= 1'b0;
    end
  end

endmodule
